// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register file, decoder, ID-resolved branches/jumps, hazard detection, ID/EX register.
// Optional macro BRANCH_FWD_EN forwards a non-load MEM result into the branch/jr compare.
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc_4,
    input  logic [31:0]       if_instr,
    input  logic              ex_ready,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_reg_write,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    output logic              id_stall,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              id_ex_valid,
    output logic [DATA_W-1:0] id_ex_a,
    output logic [DATA_W-1:0] id_ex_b,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [4:0]        id_ex_shamt,
    output logic [REG_AW-1:0] id_ex_dest,
    output logic [3:0]        id_ex_alu_op,
    output logic              id_ex_alu_src_imm,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_write,
    output logic              id_ex_mem_read
);

    localparam int NREGS = 1 << REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                           F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25,
                           F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10;

    logic [DATA_W-1:0] rf_q [NREGS];

    logic [5:0]        opcode_s, funct_s;
    logic [REG_AW-1:0] rs_s, rt_s, rd_s;
    logic [DATA_W-1:0] rs_val_s, rt_val_s, cmp_rs_s, cmp_rt_s;
    logic [DATA_W-1:0] imm_sext_s, imm_s, a_s, b_s, target_s;
    logic [3:0]        alu_op_s;
    logic [REG_AW-1:0] dest_s;
    logic              src_imm_s, rw_s, mw_s, mr_s, zext_s, uses_rt_s;
    logic              is_beq_s, is_bne_s, is_jr_s, is_j_s, is_jal_s;
    logic              mem_haz_en_s, ex_fwd_rs_s, ex_fwd_rt_s, mem_m_rs_s, mem_m_rt_s;
    logic              load_use_s, br_haz_s, stall_s, taken_s;

    logic              valid_q, valid_d, src_imm_q, src_imm_d;
    logic              rw_q, rw_d, mw_q, mw_d, mr_q, mr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [3:0]        alu_op_q, alu_op_d;

    // r0 reads as zero; a same-cycle WB write to the read address is bypassed
    function automatic logic [DATA_W-1:0] rf_read(input logic [REG_AW-1:0] addr);
        logic [DATA_W-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (wb_reg_write && (wb_addr == addr)) begin
            val = wb_data;
        end else begin
            val = rf_q[addr];
        end
        return val;
    endfunction

    assign opcode_s = if_instr[31:26];
    assign funct_s  = if_instr[5:0];
    assign rs_s     = REG_AW'(if_instr[25:21]);
    assign rt_s     = REG_AW'(if_instr[20:16]);
    assign rd_s     = REG_AW'(if_instr[15:11]);

    // register file write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_reg_write && (wb_addr != '0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // register file read ports
    always_comb begin
        rs_val_s = rf_read(rs_s);
        rt_val_s = rf_read(rt_s);
    end

    // instruction decode; unrecognised encodings fall through as a NOP
    always_comb begin
        alu_op_s  = ALU_ADD;
        dest_s    = '0;
        src_imm_s = 1'b0;
        rw_s      = 1'b0;
        mw_s      = 1'b0;
        mr_s      = 1'b0;
        zext_s    = 1'b0;
        uses_rt_s = 1'b0;
        is_beq_s  = 1'b0;
        is_bne_s  = 1'b0;
        is_jr_s   = 1'b0;
        is_j_s    = 1'b0;
        is_jal_s  = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                uses_rt_s = 1'b1;
                dest_s    = rd_s;
                rw_s      = 1'b1;
                case (funct_s)
                    F_ADD:   alu_op_s = ALU_ADD;
                    F_SUB:   alu_op_s = ALU_SUB;
                    F_AND:   alu_op_s = ALU_AND;
                    F_OR:    alu_op_s = ALU_OR;
                    F_XOR:   alu_op_s = ALU_XOR;
                    F_NOR:   alu_op_s = ALU_NOR;
                    F_SLT:   alu_op_s = ALU_SLT;
                    F_SLL:   alu_op_s = ALU_SLL;
                    F_SRL:   alu_op_s = ALU_SRL;
                    F_SRA:   alu_op_s = ALU_SRA;
                    F_JR: begin
                        rw_s    = 1'b0;
                        is_jr_s = 1'b1;
                    end
                    default: begin
                        rw_s   = 1'b0;
                        dest_s = '0;
                    end
                endcase
            end
            OP_ADDI: begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; end
            OP_SLTI: begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; alu_op_s = ALU_SLT; end
            OP_ANDI: begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; alu_op_s = ALU_AND; zext_s = 1'b1; end
            OP_ORI:  begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; alu_op_s = ALU_OR;  zext_s = 1'b1; end
            OP_XORI: begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; alu_op_s = ALU_XOR; zext_s = 1'b1; end
            OP_LUI:  begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; alu_op_s = ALU_LUI; end
            OP_LW:   begin dest_s = rt_s; src_imm_s = 1'b1; rw_s = 1'b1; mr_s = 1'b1; end
            OP_SW:   begin dest_s = rt_s; src_imm_s = 1'b1; mw_s = 1'b1; uses_rt_s = 1'b1; end
            OP_BEQ:  begin dest_s = rt_s; alu_op_s = ALU_SUB; uses_rt_s = 1'b1; is_beq_s = 1'b1; end
            OP_BNE:  begin dest_s = rt_s; alu_op_s = ALU_SUB; uses_rt_s = 1'b1; is_bne_s = 1'b1; end
            OP_J:    begin is_j_s = 1'b1; end
            OP_JAL:  begin is_jal_s = 1'b1; rw_s = 1'b1; dest_s = REG_AW'(LINK_REG); end
            default: begin rw_s = 1'b0; end
        endcase
    end

    assign imm_sext_s = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
    assign imm_s      = zext_s ? {{(DATA_W-16){1'b0}}, if_instr[15:0]} : imm_sext_s;
    assign a_s        = is_jal_s ? if_pc_4 : rs_val_s;
    assign b_s        = is_jal_s ? '0 : rt_val_s;

`ifdef BRANCH_FWD_EN
    // a non-load result sitting in MEM can feed the compare directly
    assign cmp_rs_s     = (mem_reg_write && !mem_is_load && (rs_s != '0) && (mem_dest == rs_s)) ? mem_result : rs_val_s;
    assign cmp_rt_s     = (mem_reg_write && !mem_is_load && (rt_s != '0) && (mem_dest == rt_s)) ? mem_result : rt_val_s;
    assign mem_haz_en_s = mem_reg_write & mem_is_load;
`else
    logic unused_mem_s;
    assign unused_mem_s = ^{mem_is_load, mem_result};
    assign cmp_rs_s     = rs_val_s;
    assign cmp_rt_s     = rt_val_s;
    assign mem_haz_en_s = mem_reg_write;
`endif

    assign ex_fwd_rs_s = valid_q & rw_q & (dest_q == rs_s);
    assign ex_fwd_rt_s = valid_q & rw_q & (dest_q == rt_s);
    assign mem_m_rs_s  = mem_haz_en_s & (mem_dest == rs_s);
    assign mem_m_rt_s  = mem_haz_en_s & (mem_dest == rt_s);

    assign load_use_s = if_valid & valid_q & mr_q & (dest_q != '0) &
                        ((dest_q == rs_s) | (uses_rt_s & (dest_q == rt_s)));
    assign br_haz_s   = if_valid & (is_beq_s | is_bne_s | is_jr_s) &
                        (((rs_s != '0) & (ex_fwd_rs_s | mem_m_rs_s)) |
                         ((is_beq_s | is_bne_s) & (rt_s != '0) & (ex_fwd_rt_s | mem_m_rt_s)));
    assign stall_s    = load_use_s | br_haz_s | ~ex_ready;
    assign taken_s    = is_j_s | is_jal_s | is_jr_s |
                        (is_beq_s & (cmp_rs_s == cmp_rt_s)) | (is_bne_s & (cmp_rs_s != cmp_rt_s));

    // redirect target select
    always_comb begin
        if (is_jr_s) begin
            target_s = cmp_rs_s;
        end else if (is_j_s || is_jal_s) begin
            target_s = {if_pc_4[DATA_W-1:28], if_instr[25:0], 2'b00};
        end else begin
            target_s = if_pc_4 + (imm_sext_s << 2);
        end
    end

    assign id_stall       = if_valid & stall_s;
    assign redirect_valid = if_valid & ~stall_s & taken_s;
    assign redirect_pc    = redirect_valid ? target_s : '0;

    // ID/EX next state: hold on backpressure, bubble on hazard, else load
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        shamt_d   = shamt_q;
        dest_d    = dest_q;
        alu_op_d  = alu_op_q;
        src_imm_d = src_imm_q;
        rw_d      = rw_q;
        mw_d      = mw_q;
        mr_d      = mr_q;
        if (ex_ready) begin
            if (load_use_s || br_haz_s) begin
                valid_d   = 1'b0;
                a_d       = '0;
                b_d       = '0;
                imm_d     = '0;
                shamt_d   = '0;
                dest_d    = '0;
                alu_op_d  = ALU_ADD;
                src_imm_d = 1'b0;
                rw_d      = 1'b0;
                mw_d      = 1'b0;
                mr_d      = 1'b0;
            end else begin
                valid_d   = if_valid;
                a_d       = a_s;
                b_d       = b_s;
                imm_d     = imm_s;
                shamt_d   = if_instr[10:6];
                dest_d    = dest_s;
                alu_op_d  = alu_op_s;
                src_imm_d = src_imm_s;
                rw_d      = if_valid & rw_s;
                mw_d      = if_valid & mw_s;
                mr_d      = if_valid & mr_s;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
            dest_q    <= '0;
            alu_op_q  <= ALU_ADD;
            src_imm_q <= 1'b0;
            rw_q      <= 1'b0;
            mw_q      <= 1'b0;
            mr_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
            dest_q    <= dest_d;
            alu_op_q  <= alu_op_d;
            src_imm_q <= src_imm_d;
            rw_q      <= rw_d;
            mw_q      <= mw_d;
            mr_q      <= mr_d;
        end
    end

    assign id_ex_valid       = valid_q;
    assign id_ex_a           = a_q;
    assign id_ex_b           = b_q;
    assign id_ex_imm         = imm_q;
    assign id_ex_shamt       = shamt_q;
    assign id_ex_dest        = dest_q;
    assign id_ex_alu_op      = alu_op_q;
    assign id_ex_alu_src_imm = src_imm_q;
    assign id_ex_reg_write   = rw_q;
    assign id_ex_mem_write   = mw_q;
    assign id_ex_mem_read    = mr_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected ID/EX records are queued on issue and popped after the load edge.
module tb_id_stage_pipe;

    typedef struct packed {
        logic        v;
        logic [31:0] a, b, imm;
        logic [4:0]  sh, dest;
        logic [3:0]  op;
        logic        si, rw, mw, mr;
    } idex_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        if_valid = 1'b0, ex_ready = 1'b1;
    logic [31:0] if_pc_4 = 32'h0, if_instr = 32'h0;
    logic        wb_reg_write = 1'b0, mem_reg_write = 1'b0, mem_is_load = 1'b0;
    logic [4:0]  wb_addr = 5'd0, mem_dest = 5'd0;
    logic [31:0] wb_data = 32'h0, mem_result = 32'h0;
    logic        id_stall, redirect_valid;
    logic [31:0] redirect_pc, id_ex_a, id_ex_b, id_ex_imm;
    logic        id_ex_valid, id_ex_alu_src_imm, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read;
    logic [4:0]  id_ex_shamt, id_ex_dest;
    logic [3:0]  id_ex_alu_op;

    idex_t       sb_q[$];
    idex_t       exp_r;
    logic [31:0] rf_m [32];
    int          n_chk = 0, n_fail = 0;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc_4(if_pc_4), .if_instr(if_instr),
        .ex_ready(ex_ready), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_dest(mem_dest),
        .mem_result(mem_result), .id_stall(id_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ex_valid(id_ex_valid), .id_ex_a(id_ex_a), .id_ex_b(id_ex_b),
        .id_ex_imm(id_ex_imm), .id_ex_shamt(id_ex_shamt), .id_ex_dest(id_ex_dest),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src_imm(id_ex_alu_src_imm),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_mem_read(id_ex_mem_read)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic idex_t obs();
        return '{id_ex_valid, id_ex_a, id_ex_b, id_ex_imm, id_ex_shamt, id_ex_dest, id_ex_alu_op,
                 id_ex_alu_src_imm, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read};
    endfunction

    function automatic idex_t mk(input logic v, input logic [31:0] a, b, imm, input logic [4:0] sh, dest,
                                 input logic [3:0] op, input logic si, rw, mw, mr);
        return '{v, a, b, imm, sh, dest, op, si, rw, mw, mr};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, rt, rd, sh, fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, rs, rt, imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] x);
        return {{16{x[15]}}, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] ins);
        if_valid = v;
        if_pc_4  = pc4;
        if_instr = ins;
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        drive(1'b0, 32'h0, 32'h0);
        wb_reg_write = 1'b1;
        wb_addr      = addr;
        wb_data      = data;
        tick();
        wb_reg_write = 1'b0;
        rf_m[addr]   = data;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        rst = 1'b0;
        drive(1'b1, 32'h4, enc_r(0, 0, 1, 0, 'h20));
        tick();
        tick();
        n_chk++;
        if (obs() !== idex_t'(0)) begin
            n_fail++; $display("FAIL reset_idex: got %h expected %h", obs(), idex_t'(0));
        end
        drive(1'b0, 32'h0, 32'h0);
        n_chk++;
        if ({id_stall, redirect_valid, redirect_pc} !== 34'h0) begin
            n_fail++; $display("FAIL reset_comb: got %b/%b/%h expected 0/0/0", id_stall, redirect_valid, redirect_pc);
        end
        rst = 1'b1;
    endtask

    task automatic test_wb_bypass();
        logic [31:0] ins;
        ins = enc_r(5, 0, 3, 0, 'h20);
        wb_reg_write = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
        drive(1'b1, 32'h4, ins);
        n_chk++;
        if (id_stall !== 1'b0) begin
            n_fail++; $display("FAIL bypass_nostall: got %b expected 0", id_stall);
        end
        sb_q.push_back(mk(1'b1, 32'd7, 32'd0, sext16(ins[15:0]), ins[10:6], 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        wb_reg_write = 1'b0; rf_m[5] = 32'd7;
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL bypass_idex: got %h expected %h", obs(), exp_r);
        end
        ins = enc_r(5, 5, 8, 0, 'h22);
        drive(1'b1, 32'h8, ins);
        sb_q.push_back(mk(1'b1, rf_m[5], rf_m[5], sext16(ins[15:0]), ins[10:6], 5'd8, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL regfile_read: got %h expected %h", obs(), exp_r);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] ins;
        wb_write(5'd1, 32'h100);
        wb_write(5'd2, 32'h22);
        drive(1'b1, 32'h8, enc_i('h23, 1, 2, 0));
        sb_q.push_back(mk(1'b1, 32'h100, 32'h22, 32'h0, 5'd0, 5'd2, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL lw_idex: got %h expected %h", obs(), exp_r);
        end
        ins = enc_r(2, 2, 4, 0, 'h20);
        drive(1'b1, 32'hC, ins);
        n_chk++;
        if (id_stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: got %b expected 1", id_stall);
        end
        tick();
        n_chk++;
        if (obs() !== idex_t'(0)) begin
            n_fail++; $display("FAIL load_use_bubble: got %h expected %h", obs(), idex_t'(0));
        end
        n_chk++;
        if (id_stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release: got %b expected 0", id_stall);
        end
        sb_q.push_back(mk(1'b1, 32'h22, 32'h22, sext16(ins[15:0]), ins[10:6], 5'd4, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL load_use_add: got %h expected %h", obs(), exp_r);
        end
        drive(1'b1, 32'h10, enc_i('h23, 1, 2, 4));
        tick();
        drive(1'b1, 32'h14, enc_i('h08, 0, 2, 1));
        n_chk++;
        if (id_stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_rt_itype: got %b expected 0", id_stall);
        end
        sb_q.push_back(mk(1'b1, 32'h0, 32'h22, 32'h1, 5'd0, 5'd2, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL addi_idex: got %h expected %h", obs(), exp_r);
        end
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'h55);
        drive(1'b1, 32'h100, enc_i(4, 1, 1, 4));
        n_chk++;
        if ({id_stall, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h110}) begin
            n_fail++; $display("FAIL beq_taken: got %b/%b/%h expected 0/1/00000110", id_stall, redirect_valid, redirect_pc);
        end
        sb_q.push_back(mk(1'b1, 32'h55, 32'h55, 32'h4, 5'd0, 5'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL beq_idex: got %h expected %h", obs(), exp_r);
        end
        drive(1'b1, 32'h104, enc_i(5, 1, 1, 4));
        n_chk++;
        if ({id_stall, redirect_valid} !== 2'b00) begin
            n_fail++; $display("FAIL bne_not_taken: got %b/%b expected 0/0", id_stall, redirect_valid);
        end
        tick();
        drive(1'b1, 32'h200, enc_i(5, 1, 0, 'hFFFE));
        n_chk++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1F8}) begin
            n_fail++; $display("FAIL bne_neg_offset: got %b/%h expected 1/000001f8", redirect_valid, redirect_pc);
        end
        tick();
        drive(1'b1, 32'h204, enc_i('h3F, 0, 0, 0));
        tick();
        n_chk++;
        if ({id_ex_valid, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read} !== 4'b1000) begin
            n_fail++; $display("FAIL nop_opcode: got %b%b%b%b expected 1000", id_ex_valid, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read);
        end
        drive(1'b1, 32'h208, enc_r(1, 1, 9, 0, 'h21));
        tick();
        n_chk++;
        if ({id_ex_valid, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read} !== 4'b1000) begin
            n_fail++; $display("FAIL nop_funct: got %b%b%b%b expected 1000", id_ex_valid, id_ex_reg_write, id_ex_mem_write, id_ex_mem_read);
        end
    endtask

    task automatic test_jump();
        logic [31:0] ins;
        ins = enc_j(3, 'h40);
        drive(1'b1, 32'h00400008, ins);
        n_chk++;
        if ({id_stall, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++; $display("FAIL jal_redirect: got %b/%b/%h expected 0/1/00000100", id_stall, redirect_valid, redirect_pc);
        end
        sb_q.push_back(mk(1'b1, 32'h00400008, 32'h0, sext16(ins[15:0]), ins[10:6], 5'd31, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL jal_idex: got %h expected %h", obs(), exp_r);
        end
        drive(1'b1, 32'hA0000004, enc_j(2, 'h3FFFFFF));
        n_chk++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'hAFFFFFFC}) begin
            n_fail++; $display("FAIL j_upper_bits: got %b/%h expected 1/affffffc", redirect_valid, redirect_pc);
        end
        tick();
        drive(1'b1, 32'h50, enc_r(1, 0, 0, 0, 8));
        n_chk++;
        if ({id_stall, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h55}) begin
            n_fail++; $display("FAIL jr_redirect: got %b/%b/%h expected 0/1/00000055", id_stall, redirect_valid, redirect_pc);
        end
        tick();
        drive(1'b1, 32'h54, enc_i(8, 0, 1, 'h77));
        tick();
        drive(1'b1, 32'h58, enc_r(1, 0, 0, 0, 8));
        n_chk++;
        if ({id_stall, redirect_valid} !== 2'b10) begin
            n_fail++; $display("FAIL jr_ex_hazard: got %b/%b expected 1/0", id_stall, redirect_valid);
        end
        tick();
        n_chk++;
        if ({id_stall, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h55}) begin
            n_fail++; $display("FAIL jr_after_bubble: got %b/%b/%h expected 0/1/00000055", id_stall, redirect_valid, redirect_pc);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins;
        ins = enc_i('h0D, 0, 7, 'hFFFF);
        drive(1'b1, 32'h300, ins);
        sb_q.push_back(mk(1'b1, 32'h0, rf_m[7], 32'h0000FFFF, ins[10:6], 5'd7, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL ori_idex: got %h expected %h", obs(), exp_r);
        end
        ex_ready = 1'b0;
        drive(1'b1, 32'h304, enc_i(4, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({id_stall, redirect_valid} !== 2'b10) begin
                n_fail++; $display("FAIL bp_stall[%0d]: got %b/%b expected 1/0", k, id_stall, redirect_valid);
            end
            tick();
            n_chk++;
            if (obs() !== exp_r) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, obs(), exp_r);
            end
            n_chk++;
            if (id_ex_imm !== 32'h0000FFFF) begin
                n_fail++; $display("FAIL bp_imm[%0d]: got %h expected 0000ffff", k, id_ex_imm);
            end
        end
        ex_ready = 1'b1;
        #1;
        n_chk++;
        if ({id_stall, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h308}) begin
            n_fail++; $display("FAIL bp_release: got %b/%b/%h expected 0/1/00000308", id_stall, redirect_valid, redirect_pc);
        end
        sb_q.push_back(mk(1'b1, 32'h0, 32'h0, 32'h1, 5'd0, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL bp_beq_idex: got %h expected %h", obs(), exp_r);
        end
    endtask

    task automatic test_mem_branch();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        mem_reg_write = 1'b1; mem_is_load = 1'b0; mem_dest = 5'd6; mem_result = 32'd5;
        drive(1'b1, 32'h400, enc_i(4, 6, 0, 2));
`ifndef BRANCH_FWD_EN
        n_chk++;
        if ({id_stall, redirect_valid} !== 2'b10) begin
            n_fail++; $display("FAIL mem_haz_stall: got %b/%b expected 1/0", id_stall, redirect_valid);
        end
        tick();
        n_chk++;
        if (obs() !== idex_t'(0)) begin
            n_fail++; $display("FAIL mem_haz_bubble: got %h expected %h", obs(), idex_t'(0));
        end
        mem_reg_write = 1'b0;
        wb_reg_write = 1'b1; wb_addr = 5'd6; wb_data = 32'd5;
        #1;
        n_chk++;
        if ({id_stall, redirect_valid} !== 2'b00) begin
            n_fail++; $display("FAIL mem_haz_release: got %b/%b expected 0/0", id_stall, redirect_valid);
        end
        sb_q.push_back(mk(1'b1, 32'd5, 32'h0, 32'h2, 5'd0, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        wb_reg_write = 1'b0; rf_m[6] = 32'd5;
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL mem_beq_idex: got %h expected %h", obs(), exp_r);
        end
`else
        n_chk++;
        if ({id_stall, redirect_valid} !== 2'b00) begin
            n_fail++; $display("FAIL mem_fwd_nostall: got %b/%b expected 0/0", id_stall, redirect_valid);
        end
        sb_q.push_back(mk(1'b1, rf_m[6], 32'h0, 32'h2, 5'd0, 5'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        exp_r = sb_q.pop_front();
        n_chk++;
        if (obs() !== exp_r) begin
            n_fail++; $display("FAIL mem_fwd_idex: got %h expected %h", obs(), exp_r);
        end
        mem_is_load = 1'b1;
        #1;
        n_chk++;
        if ({id_stall, redirect_valid} !== 2'b10) begin
            n_fail++; $display("FAIL mem_load_stall: got %b/%b expected 1/0", id_stall, redirect_valid);
        end
        tick();
`endif
        mem_reg_write = 1'b0; mem_is_load = 1'b0;
    endtask

    task automatic test_reset_hold();
        ex_ready = 1'b0;
        drive(1'b1, 32'h500, enc_i(8, 0, 3, 9));
        rst = 1'b0;
        tick();
        n_chk++;
        if (obs() !== idex_t'(0)) begin
            n_fail++; $display("FAIL reset_over_hold: got %h expected %h", obs(), idex_t'(0));
        end
        rst = 1'b1;
        ex_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_load_use();
        test_branch();
        test_jump();
        test_backpressure();
        test_mem_branch();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 5-stage MIPS pipeline, successor to the existing ID logic.
- Holds the register file internally and decodes the instruction word. Resolves branches and jumps in ID, detects load-use and branch hazards, and owns the ID/EX pipeline register.
- Supports backpressure from EX and emits a PC redirect plus an IF/ID flush to the fetch stage.
- Fixes the jal link path: pc_4 is driven as the ALU A operand.

Parameters:
- DATA_W, 32, datapath width; must be ≥32; jump target takes its upper DATA_W-28 bits from pc_4.
- REG_AW, 5, register address width; register file has 2^REG_AW entries.
- LINK_REG, 31, destination register written by jal.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- if_valid  in  1  IF/ID holds a real instruction.
- if_pc_4  in  DATA_W  PC+4 of that instruction.
- if_instr  in  32  instruction word.
- ex_ready  in  1  EX accepts the ID/EX contents this cycle.
- wb_reg_write  in  1  writeback enable.
- wb_addr  in  REG_AW  writeback register.
- wb_data  in  DATA_W  writeback data.
- mem_reg_write  in  1  MEM-stage instruction writes a register.
- mem_is_load  in  1  MEM-stage instruction is lw.
- mem_dest  in  REG_AW  MEM-stage destination.
- mem_result  in  DATA_W  MEM-stage ALU result.
- id_stall  out  1  hold PC and IF/ID.
- redirect_valid  out  1  take redirect_pc; IF must discard its fetched word.
- redirect_pc  out  DATA_W  branch/jump target.
- id_ex_valid  out  1  ID/EX holds a real instruction.
- id_ex_a, id_ex_b  out  DATA_W  operand A (rs or pc_4) and operand B (rt or 0).
- id_ex_imm  out  DATA_W  extended immediate.
- id_ex_shamt  out  5  shift amount.
- id_ex_dest  out  REG_AW  destination register.
- id_ex_alu_op  out  4  ALU operation.
- id_ex_alu_src_imm  out  1  B input takes the immediate.
- id_ex_reg_write, id_ex_mem_write, id_ex_mem_read  out  1 each  control bits.

Behaviour:
- Reset (rst=0 at a clk edge): all registers and every id_ex_* output go to 0, so id_ex_valid=0. Combinational outputs then evaluate to 0 for if_valid=0.
- Register file:
  - r0 is hardwired to 0.
  - A write occurs at the edge when wb_reg_write=1 and wb_addr≠0.
  - Reads are combinational with WB bypass: a same-cycle write to the read address returns wb_data.
- Decoded subset:
  - R-type: add, sub, and, or, xor, nor, slt, sll, srl, sra, jr.
  - I-type: addi, andi, ori, xori, lui, slti, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other opcode or funct decodes as a NOP: id_ex_valid=1 with all write enables 0.
- alu_op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 LUI.
- Immediate: zero-extended for andi/ori/xori, sign-extended to DATA_W otherwise.
- Destination: rd for R-type, rt for I-type, LINK_REG for jal.
- jal operands and control: A=pc_4, B=0, alu_op ADD, reg_write=1.
- Targets:
  - Branch: pc_4 + (sext(imm)<<2), modulo 2^DATA_W.
  - j/jal: {pc_4[DATA_W-1:28], instr[25:0], 2'b00}.
  - jr: the rs value.
- Hazard conditions, each evaluated only when if_valid=1:
  - load_use: id_ex_valid & id_ex_mem_read & id_ex_dest≠0, and id_ex_dest equals a source this instruction actually uses (rs; rt only for R-type, sw, beq, bne).
  - br_haz: the instruction is beq/bne/jr and a compared source ≠0 matches id_ex_dest while id_ex_valid & id_ex_reg_write, or matches mem_dest while mem_reg_write (MEM matching subject to the optional feature).
- stall = load_use | br_haz | ~ex_ready; id_stall = if_valid & stall.
- ID/EX update at each edge:
  - ex_ready=0: hold all contents.
  - ex_ready=1 and (load_use | br_haz): load a bubble, id_ex_valid=0 with all enables 0.
  - ex_ready=1 otherwise: load the decoded instruction, id_ex_valid=if_valid.
- Redirect:
  - redirect_valid = if_valid & ~stall & (j | jal | jr | (beq & eq) | (bne & ~eq)). The architectural delay slot is not supported.
  - The branch/jump itself still enters ID/EX; jal writes its link there.
- Simultaneous events:
  - WB writing a register that ID reads resolves through the bypass, with no stall.
  - A stall suppresses redirect in the same cycle.
  - Reset overrides stall and hold.

Optional Feature:
- Macro: BRANCH_FWD_EN.
- Defined: the beq/bne/jr compare operand is taken from mem_result when mem_reg_write & ~mem_is_load & mem_dest matches it. The MEM term of br_haz then applies only when mem_is_load=1.
- Undefined: any MEM-stage match stalls until the producer reaches WB.

Test Plan:
- Reset, then write r5=7 via WB in the same cycle an ID `add r3,r5,r0` is presented → next edge id_ex_a=7, id_ex_dest=3, id_ex_alu_op=0.
- `lw r2,0(r1)` followed by `add r4,r2,r2` → one cycle with id_stall=1 and a bubble (id_ex_valid=0), then the add enters ID/EX.
- `beq r1,r1,+4` at pc_4=0x100 → redirect_valid=1, redirect_pc=0x110; `bne r1,r1` gives redirect_valid=0.
- `jal 0x40` at pc_4=0x00400008 → redirect_pc=0x00000100, id_ex_dest=31, id_ex_a=0x00400008, id_ex_b=0.
- ex_ready=0 for 3 cycles with a valid `ori r7,r0,0xFFFF` → ID/EX unchanged, id_stall=1 throughout; id_ex_imm=0x0000FFFF.
- `addi r6,r0,5` in MEM with a `beq r6,r0` in ID → 1 stall cycle without BRANCH_FWD_EN; no stall and not taken with it.
